// File: rtl/ca_pkg.sv
// Shared definitions for the memory stage: FSM state encoding, default
// data-memory geometry and the MEM/WB pipeline register payload.
package ca_pkg;

    localparam logic [31:0]  BASE_ADDR_DEF   = 32'd1024;
    localparam int unsigned  WAIT_CYCLES_DEF = 2;
    localparam int unsigned  SRAM_AW_DEF     = 18;
    localparam int unsigned  SRAM_DW         = 16;
    localparam int unsigned  WORD_W          = 32;
    localparam int unsigned  REG_W           = 4;
    localparam int unsigned  CNT_W           = 4;

    // Access sequencer: low half-word phase, then high half-word phase.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    // MEM/WB pipeline register contents.
    typedef struct packed {
        logic              wb_en;
        logic              mem_r;
        logic [WORD_W-1:0] alu_res;
        logic [WORD_W-1:0] mem_data;
        logic [REG_W-1:0]  dest;
    } mem_wb_t;

endpackage

// File: rtl/sram_ctrl.sv
// Two-phase 16-bit SRAM access sequencer for 32-bit loads and stores.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   start_i          memory request pending (load or store)
//   rw_i             1 = read, 0 = write
//   addr_i           word index; half-word address is {addr_i, phase}
//   wdata_i          32-bit store data
//   rdata_o          assembled 32-bit load data {high, low}
//   ready_o          0 while an access is in progress (combinational)
//   sram_*           external SRAM address, data and active-low strobes
module sram_ctrl
    import ca_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int unsigned SRAM_AW     = SRAM_AW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                rw_i,
    input  logic [SRAM_AW-2:0]  addr_i,
    input  logic [WORD_W-1:0]   wdata_i,
    output logic [WORD_W-1:0]   rdata_o,
    output logic                ready_o,
    output logic [SRAM_AW-1:0]  sram_addr_o,
    output logic [SRAM_DW-1:0]  sram_wdata_o,
    input  logic [SRAM_DW-1:0]  sram_rdata_i,
    output logic                sram_we_n_o,
    output logic                sram_oe_n_o
);

    mem_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SRAM_DW-1:0]  lo_q, lo_d;
    logic [SRAM_DW-1:0]  hi_q, hi_d;
    logic                last_c;
    logic                req_c;

    assign last_c  = (cnt_q == CNT_W'(WAIT_CYCLES - 1));
    // A request still presented by frozen upstream logic is ignored while reset is held.
    assign req_c   = start_i & rst;
    assign rdata_o = {hi_q, lo_q};

    // State, phase counter and captured half-words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // Next state, strobes and read capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        ready_o      = 1'b1;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_we_n_o  = 1'b1;
        sram_oe_n_o  = 1'b1;

        case (state_q)
            IDLE: begin
                if (req_c) begin
                    ready_o = 1'b0;
                    state_d = LO;
                    cnt_d   = '0;
                end
            end
            LO: begin
                ready_o     = 1'b0;
                sram_addr_o = {addr_i, 1'b0};
                if (rw_i) begin
                    sram_oe_n_o = 1'b0;
                    if (last_c) lo_d = sram_rdata_i;
                end else begin
                    sram_wdata_o = wdata_i[15:0];
                    // Release WE on the last cycle so the address changes with WE high.
                    sram_we_n_o  = last_c;
                end
                if (last_c) begin
                    state_d = HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            HI: begin
                ready_o     = 1'b0;
                sram_addr_o = {addr_i, 1'b1};
                if (rw_i) begin
                    sram_oe_n_o = 1'b0;
                    if (last_c) hi_d = sram_rdata_i;
                end else begin
                    sram_wdata_o = wdata_i[31:16];
                    sram_we_n_o  = last_c;
                end
                if (last_c) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: maps the ALU result to an SRAM word index, runs
// loads/stores through sram_ctrl (freezing the pipeline while busy) and
// holds the MEM/WB register. Non-memory instructions pass in one cycle.
// Ports:
//   clk, rst                           clock, asynchronous active-low reset
//   WB_EN, MEM_R, MEM_W, ALU_res,
//   val_rm, dest                       EXE stage outputs
//   ready                              0 = memory busy, pipeline freezes
//   WB_EN_out, MEM_R_out, ALU_res_out,
//   mem_data, dest_out                 MEM/WB register
//   sram_*                             external 16-bit SRAM
module mem_stage
    import ca_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int unsigned SRAM_AW     = SRAM_AW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                WB_EN,
    input  logic                MEM_R,
    input  logic                MEM_W,
    input  logic [WORD_W-1:0]   ALU_res,
    input  logic [WORD_W-1:0]   val_rm,
    input  logic [REG_W-1:0]    dest,
    output logic                ready,
    output logic                WB_EN_out,
    output logic                MEM_R_out,
    output logic [WORD_W-1:0]   ALU_res_out,
    output logic [WORD_W-1:0]   mem_data,
    output logic [REG_W-1:0]    dest_out,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [SRAM_DW-1:0]  sram_wdata,
    input  logic [SRAM_DW-1:0]  sram_rdata,
    output logic                sram_we_n,
    output logic                sram_oe_n
);

    logic [WORD_W-1:0]   offset_c;
    logic [SRAM_AW-2:0]  word_idx_c;
    logic [WORD_W-1:0]   rdata_c;
    mem_wb_t             mem_wb_q, mem_wb_d;

    // Byte offset wraps modulo 2^32; byte-in-word bits are dropped.
    assign offset_c   = ALU_res - BASE_ADDR;
    assign word_idx_c = (SRAM_AW-1)'(offset_c >> 2);

    sram_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .SRAM_AW     (SRAM_AW)
    ) u_sram_ctrl (
        .clk          (clk),
        .rst          (rst),
        .start_i      (MEM_R | MEM_W),
        .rw_i         (MEM_R),
        .addr_i       (word_idx_c),
        .wdata_i      (val_rm),
        .rdata_o      (rdata_c),
        .ready_o      (ready),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_rdata_i (sram_rdata),
        .sram_we_n_o  (sram_we_n),
        .sram_oe_n_o  (sram_oe_n)
    );

    // ready is high only when idle without a request or on completion, so a
    // set MEM_R here always means the assembled load word is valid.
    always_comb begin
        mem_wb_d = '0;
        if (ready) begin
            mem_wb_d.wb_en    = WB_EN;
            mem_wb_d.mem_r    = MEM_R;
            mem_wb_d.alu_res  = ALU_res;
            mem_wb_d.mem_data = MEM_R ? rdata_c : '0;
            mem_wb_d.dest     = dest;
        end
    end

    // MEM/WB pipeline register; bubbles while the stage is busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wb_q <= '0;
        end else begin
            mem_wb_q <= mem_wb_d;
        end
    end

    assign WB_EN_out   = mem_wb_q.wb_en;
    assign MEM_R_out   = mem_wb_q.mem_r;
    assign ALU_res_out = mem_wb_q.alu_res;
    assign mem_data    = mem_wb_q.mem_data;
    assign dest_out    = mem_wb_q.dest;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a behavioural SRAM and a
// word-level reference memory.
`timescale 1ns/1ps
module tb_mem_stage;

    localparam int unsigned W    = 2;
    localparam logic [31:0] BASE = 32'd1024;
    localparam int          AW   = 18;
    localparam int          PER  = 10;
    localparam int          MEMSZ = 262144;

    logic        clk, rst;
    logic        WB_EN, MEM_R, MEM_W;
    logic [31:0] ALU_res, val_rm;
    logic [3:0]  dest;
    logic        ready, WB_EN_out, MEM_R_out;
    logic [31:0] ALU_res_out, mem_data;
    logic [3:0]  dest_out;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata;
    logic        sram_we_n, sram_oe_n;

    int errors = 0;
    int checks = 0;

    mem_stage #(.BASE_ADDR(BASE), .WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst), .WB_EN(WB_EN), .MEM_R(MEM_R), .MEM_W(MEM_W),
        .ALU_res(ALU_res), .val_rm(val_rm), .dest(dest), .ready(ready),
        .WB_EN_out(WB_EN_out), .MEM_R_out(MEM_R_out), .ALU_res_out(ALU_res_out),
        .mem_data(mem_data), .dest_out(dest_out), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    initial clk = 1'b0;
    always #(PER/2) clk = ~clk;

    // Fill pattern for half-words never written.
    function automatic logic [15:0] pat(input logic [17:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'd40503;
        return t[15:0] ^ 16'h5A5A;
    endfunction

    // Behavioural SRAM device.
    logic [15:0] dev   [0:MEMSZ-1];
    bit          dev_v [0:MEMSZ-1];
    always @(posedge clk) begin
        if (sram_we_n === 1'b0) begin
            dev[sram_addr]   <= sram_wdata;
            dev_v[sram_addr] <= 1'b1;
        end
    end
    always @(negedge clk) sram_rdata <= dev_v[sram_addr] ? dev[sram_addr] : pat(sram_addr);

    // Reference memory, updated by the model only.
    logic [15:0] shd   [0:MEMSZ-1];
    bit          shd_v [0:MEMSZ-1];

    function automatic logic [15:0] mrd(input logic [17:0] a);
        return shd_v[a] ? shd[a] : pat(a);
    endfunction

    function automatic logic [31:0] model_word(input logic [17:0] lo);
        return {mrd(lo + 18'd1), mrd(lo)};
    endfunction

    task automatic model_store(input logic [17:0] lo, input logic [31:0] d);
        shd[lo]          = d[15:0];
        shd_v[lo]        = 1'b1;
        shd[lo + 18'd1]  = d[31:16];
        shd_v[lo + 18'd1] = 1'b1;
    endtask

    // Low half-word address of the word holding byte address alu.
    function automatic logic [17:0] exp_lo_addr(input logic [31:0] alu);
        logic [31:0] off;
        off = alu - BASE;
        return 18'((off / 32'd4) % 32'd131072 * 32'd2);
    endfunction

    // Observations of the last run_op.
    int          stall, bub_bad, wr_lo, wr_hi, rd_lo, rd_hi, acc_bad;
    longint      t_first, t_last;
    logic [17:0] first_acc_addr;
    logic        o_wb, o_mr;
    logic [31:0] o_alu, o_mem;
    logic [3:0]  o_dest;

    // Present one instruction just after a rising edge, watch it until it
    // completes and capture the MEM/WB register after the completing edge.
    task automatic run_op(input logic wb, input logic r, input logic w,
                          input logic [31:0] alu, input logic [31:0] rm, input logic [3:0] d);
        logic [17:0] lo;
        lo = exp_lo_addr(alu);
        WB_EN = wb; MEM_R = r; MEM_W = w; ALU_res = alu; val_rm = rm; dest = d;
        stall = 0; bub_bad = 0; wr_lo = 0; wr_hi = 0; rd_lo = 0; rd_hi = 0; acc_bad = 0;
        first_acc_addr = '1; t_first = 0; t_last = 0;
        @(negedge clk);
        while (ready !== 1'b1 && stall < 100) begin
            if (stall == 0) t_first = $time;
            t_last = $time;
            if (stall > 0 && (WB_EN_out !== 1'b0 || MEM_R_out !== 1'b0 || ALU_res_out !== 32'd0
                              || mem_data !== 32'd0 || dest_out !== 4'd0)) bub_bad++;
            if (sram_we_n === 1'b0) begin
                if (first_acc_addr == 18'h3FFFF) first_acc_addr = sram_addr;
                if (sram_addr === lo && sram_wdata === rm[15:0] && wr_hi == 0) wr_lo++;
                else if (sram_addr === lo + 18'd1 && sram_wdata === rm[31:16] && wr_lo > 0) wr_hi++;
                else acc_bad++;
            end
            if (sram_oe_n === 1'b0) begin
                if (first_acc_addr == 18'h3FFFF) first_acc_addr = sram_addr;
                if (sram_addr === lo && rd_hi == 0) rd_lo++;
                else if (sram_addr === lo + 18'd1 && rd_lo > 0) rd_hi++;
                else acc_bad++;
            end
            stall++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        o_wb = WB_EN_out; o_mr = MEM_R_out; o_alu = ALU_res_out; o_mem = mem_data; o_dest = dest_out;
        WB_EN = 1'b0; MEM_R = 1'b0; MEM_W = 1'b0; ALU_res = '0; val_rm = '0; dest = '0;
    endtask

    task automatic test_reset();
        logic [31:0] word;
        checks++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) begin
            errors++; $display("FAIL reset_strobes: got ready/we_n/oe_n=%b%b%b expected 111", ready, sram_we_n, sram_oe_n);
        end
        checks++;
        if ({WB_EN_out, MEM_R_out, ALU_res_out, mem_data, dest_out, sram_addr, sram_wdata} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h %h %h addr=%h wdata=%h expected all zero",
                               ALU_res_out, mem_data, dest_out, sram_addr, sram_wdata);
        end
        @(negedge clk); rst = 1'b1;
        // Start a store and reset it in the first LO cycle.
        @(posedge clk); #1;
        MEM_W = 1'b1; ALU_res = 32'd2000; val_rm = 32'h1111_2222; dest = 4'd9; WB_EN = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if (sram_we_n !== 1'b0 || sram_addr !== exp_lo_addr(32'd2000)) begin
            errors++; $display("FAIL pre_reset_lo: got we_n=%b addr=%h expected 0 %h", sram_we_n, sram_addr, exp_lo_addr(32'd2000));
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({ready, sram_we_n, sram_oe_n} !== 3'b111) begin
            errors++; $display("FAIL midreset_strobes: got ready/we_n/oe_n=%b%b%b expected 111", ready, sram_we_n, sram_oe_n);
        end
        checks++;
        if ({WB_EN_out, MEM_R_out, ALU_res_out, mem_data, dest_out, sram_addr, sram_wdata} !== '0) begin
            errors++; $display("FAIL midreset_outputs: got addr=%h wdata=%h alu=%h expected all zero", sram_addr, sram_wdata, ALU_res_out);
        end
        @(posedge clk); #1;
        MEM_W = 1'b0; ALU_res = '0; val_rm = '0; dest = '0; WB_EN = 1'b0;
        @(negedge clk); rst = 1'b1; #1;
        checks++;
        if ({ready, sram_we_n, sram_oe_n, sram_addr} !== {3'b111, 18'd0}) begin
            errors++; $display("FAIL release_idle: got ready/we_n/oe_n=%b%b%b addr=%h expected 111 0", ready, sram_we_n, sram_oe_n, sram_addr);
        end
        @(posedge clk); #1;
        word = model_word(exp_lo_addr(32'd1032));
        run_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd2);
        checks++;
        if (stall != 2*W+1 || o_mem !== word) begin
            errors++; $display("FAIL post_reset_load: got stall=%0d data=%h expected %0d %h", stall, o_mem, 2*W+1, word);
        end
    endtask

    task automatic test_passthrough();
        run_op(1'b1, 1'b0, 1'b0, 32'd16, 32'h5555_AAAA, 4'd3);
        checks++;
        if (stall != 0) begin
            errors++; $display("FAIL pass_stall: got %0d expected 0", stall);
        end
        checks++;
        if ({o_wb, o_mr, o_alu, o_mem, o_dest} !== {1'b1, 1'b0, 32'd16, 32'd0, 4'd3}) begin
            errors++; $display("FAIL pass_outputs: got wb=%b mr=%b alu=%h mem=%h dest=%h expected 1 0 10 0 3",
                               o_wb, o_mr, o_alu, o_mem, o_dest);
        end
        @(negedge clk);
        checks++;
        if ({ready, sram_we_n, sram_oe_n, sram_addr, sram_wdata} !== {3'b111, 18'd0, 16'd0}) begin
            errors++; $display("FAIL idle_strobes: got %b%b%b addr=%h wdata=%h expected 111 0 0",
                               ready, sram_we_n, sram_oe_n, sram_addr, sram_wdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        run_op(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 4'd5);
        model_store(exp_lo_addr(32'd1032), 32'hDEAD_BEEF);
        checks++;
        if (stall != 2*W+1) begin
            errors++; $display("FAIL store_stall: got %0d expected %0d", stall, 2*W+1);
        end
        checks++;
        if (wr_lo != W-1 || wr_hi != W-1 || rd_lo + rd_hi != 0 || acc_bad != 0 || first_acc_addr !== 18'd4) begin
            errors++; $display("FAIL store_strobes: got lo=%0d hi=%0d rd=%0d bad=%0d first=%h expected %0d %0d 0 0 4",
                               wr_lo, wr_hi, rd_lo + rd_hi, acc_bad, first_acc_addr, W-1, W-1);
        end
        checks++;
        if ({o_wb, o_mr, o_alu, o_mem, o_dest} !== {1'b0, 1'b0, 32'd1032, 32'd0, 4'd5}) begin
            errors++; $display("FAIL store_outputs: got wb=%b mr=%b alu=%h mem=%h dest=%h expected 0 0 408 0 5",
                               o_wb, o_mr, o_alu, o_mem, o_dest);
        end
    endtask

    task automatic test_load();
        run_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd7);
        checks++;
        if (stall != 2*W+1 || bub_bad != 0) begin
            errors++; $display("FAIL load_stall: got stall=%0d bubble_errs=%0d expected %0d 0", stall, bub_bad, 2*W+1);
        end
        checks++;
        if (rd_lo != W || rd_hi != W || wr_lo + wr_hi != 0 || acc_bad != 0) begin
            errors++; $display("FAIL load_strobes: got lo=%0d hi=%0d wr=%0d bad=%0d expected %0d %0d 0 0",
                               rd_lo, rd_hi, wr_lo + wr_hi, acc_bad, W, W);
        end
        checks++;
        if ({o_wb, o_mr, o_alu, o_mem, o_dest} !== {1'b1, 1'b1, 32'd1032, 32'hDEAD_BEEF, 4'd7}) begin
            errors++; $display("FAIL load_outputs: got wb=%b mr=%b alu=%h mem=%h dest=%h expected 1 1 408 deadbeef 7",
                               o_wb, o_mr, o_alu, o_mem, o_dest);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] word;
        run_op(1'b1, 1'b1, 1'b0, 32'd1035, 32'd0, 4'd1);
        checks++;
        if (first_acc_addr !== 18'd4 || rd_lo != W || rd_hi != W || o_mem !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL misalign_load: got first=%h lo=%0d hi=%0d data=%h expected 4 %0d %0d deadbeef",
                               first_acc_addr, rd_lo, rd_hi, o_mem, W, W);
        end
        word = model_word(exp_lo_addr(32'd0));
        run_op(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 4'd2);
        checks++;
        if (first_acc_addr !== exp_lo_addr(32'd0) || rd_lo != W || rd_hi != W || acc_bad != 0 || o_mem !== word) begin
            errors++; $display("FAIL wrap_load: got first=%h lo=%0d hi=%0d data=%h expected %h %0d %0d %h",
                               first_acc_addr, rd_lo, rd_hi, o_mem, exp_lo_addr(32'd0), W, W, word);
        end
    endtask

    task automatic test_back_to_back();
        longint prev_last;
        int gap;
        run_op(1'b0, 1'b0, 1'b1, 32'd1032, 32'd0, 4'd0);
        model_store(exp_lo_addr(32'd1032), 32'd0);
        run_op(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 4'd0);
        model_store(exp_lo_addr(32'd1032), 32'hDEAD_BEEF);
        prev_last = t_last;
        run_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd6);
        gap = int'((t_first - prev_last) / PER) - 1;
        checks++;
        if (gap != 1 || stall != 2*W+1) begin
            errors++; $display("FAIL b2b_gap: got gap=%0d stall=%0d expected 1 %0d", gap, stall, 2*W+1);
        end
        checks++;
        if (o_mem !== 32'hDEAD_BEEF || o_dest !== 4'd6) begin
            errors++; $display("FAIL b2b_data: got %h dest=%h expected deadbeef 6", o_mem, o_dest);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int unsigned kind;
            logic wb, r, w;
            logic [31:0] alu, rm, word;
            logic [3:0] d;
            int exp_stall;
            kind = $urandom_range(0, 3);
            wb = 1'($urandom);
            r  = (kind == 2 || kind == 3);
            w  = (kind == 1 || kind == 3);
            alu = ($urandom_range(0, 1) == 0) ? BASE + 32'($urandom_range(0, 255)) : $urandom;
            rm  = $urandom;
            d   = 4'($urandom);
            word = model_word(exp_lo_addr(alu));
            exp_stall = (r || w) ? 2*W+1 : 0;
            run_op(wb, r, w, alu, rm, d);
            if (w && !r) model_store(exp_lo_addr(alu), rm);
            checks++;
            if (stall != exp_stall || bub_bad != 0) begin
                errors++; $display("FAIL rand_stall[%0d]: got stall=%0d bubble_errs=%0d expected %0d 0", i, stall, bub_bad, exp_stall);
            end
            checks++;
            if ({o_wb, o_mr, o_alu, o_mem, o_dest} !== {wb, r, alu, (r ? word : 32'd0), d}) begin
                errors++; $display("FAIL rand_outputs[%0d]: got %b %b %h %h %h expected %b %b %h %h %h", i,
                                   o_wb, o_mr, o_alu, o_mem, o_dest, wb, r, alu, (r ? word : 32'd0), d);
            end
            checks++;
            if (acc_bad != 0
                || wr_lo != ((w && !r) ? W-1 : 0) || wr_hi != ((w && !r) ? W-1 : 0)
                || rd_lo != (r ? W : 0) || rd_hi != (r ? W : 0)) begin
                errors++; $display("FAIL rand_access[%0d]: got wr=%0d/%0d rd=%0d/%0d bad=%0d for r=%b w=%b alu=%h",
                                   i, wr_lo, wr_hi, rd_lo, rd_hi, acc_bad, r, w, alu);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        WB_EN = 1'b0; MEM_R = 1'b0; MEM_W = 1'b0; ALU_res = '0; val_rm = '0; dest = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_passthrough();
        test_store();
        test_load();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
